// File: rtl/fanout_mon_pkg.sv
// Shared types and helpers for the fanout tree monitor.
package fanout_mon_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StCheck  = 2'd2,
    StFault  = 2'd3
  } state_e;

  // Increment that sticks at max instead of wrapping.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input logic [63:0] max);
    return (val >= max) ? max : val + 64'd1;
  endfunction

endpackage

// File: rtl/fanout_tree_monitor_if.sv
// Stimulus/status bundle between the fanout tree under test and its monitor.
interface fanout_tree_monitor_if
  import fanout_mon_pkg::*;
#(
  parameter int unsigned N_OUT = 20,
  parameter int unsigned CNT_W = 8
);

  logic               en;
  logic               clear_err;
  logic               tree_in;
  logic [N_OUT-1:0]   leaf;
  logic               all_ok;
  logic [N_OUT-1:0]   mismatch_vec;
  logic               err_sticky;
  logic [CNT_W-1:0]   err_count;
  logic [STATE_W-1:0] state_o;

  modport master (
    output en, clear_err, tree_in, leaf,
    input  all_ok, mismatch_vec, err_sticky, err_count, state_o
  );

  modport slave (
    input  en, clear_err, tree_in, leaf,
    output all_ok, mismatch_vec, err_sticky, err_count, state_o
  );

endinterface

// File: rtl/fanout_mon_sync.sv
// Input register stage: captures the tree root and leaves and flags root edges.
module fanout_mon_sync #(
  parameter int unsigned N_OUT = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tree_in,
  input  logic [N_OUT-1:0] leaf,
  output logic             in_q,
  output logic             edge_det,
  output logic [N_OUT-1:0] leaf_q
);

  logic in_qq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q   <= 1'b0;
      in_qq  <= 1'b0;
      leaf_q <= '0;
    end else begin
      in_q   <= tree_in;
      in_qq  <= in_q;
      leaf_q <= leaf;
    end
  end

  assign edge_det = in_q ^ in_qq;

endmodule

// File: rtl/fanout_tree_monitor.sv
// Checks every fanout leaf against the inverted root once the tree has settled,
// latching which leaves disagreed plus a sticky flag and saturating fault count.
module fanout_tree_monitor
  import fanout_mon_pkg::*;
#(
  parameter int unsigned N_OUT  = 20,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = 8
) (
  input logic                 clk,
  input logic                 rst,
  fanout_tree_monitor_if.slave mon
);

  localparam logic [3:0]       SettleRld = 4'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CntMax    = '1;

  logic             in_q;
  logic             edge_det;
  logic [N_OUT-1:0] leaf_q;
  logic [N_OUT-1:0] diff;

  state_e           state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic             all_ok_q, all_ok_d;
  logic [N_OUT-1:0] mm_q, mm_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  fanout_mon_sync #(
    .N_OUT(N_OUT)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .tree_in (mon.tree_in),
    .leaf    (mon.leaf),
    .in_q    (in_q),
    .edge_det(edge_det),
    .leaf_q  (leaf_q)
  );

  // Leaves are inverters, so each one should read the complement of the root.
  assign diff = leaf_q ^ {N_OUT{~in_q}};

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    all_ok_d = all_ok_q;
    mm_d     = mm_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;

    if (mon.clear_err) begin
      mm_d     = '0;
      sticky_d = 1'b0;
      cnt_d    = '0;
    end

    if (!mon.en) begin
      state_d  = StIdle;
      all_ok_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          all_ok_d = 1'b0;
          state_d  = StSettle;
          settle_d = SettleRld;
        end
        StSettle: begin
          all_ok_d = 1'b0;
          if (edge_det) begin
            settle_d = SettleRld;
          end else if (settle_q == 4'd0) begin
            state_d = StCheck;
          end else begin
            settle_d = settle_q - 4'd1;
          end
        end
        StCheck: begin
          if (edge_det) begin
            state_d  = StSettle;
            settle_d = SettleRld;
            all_ok_d = 1'b0;
          end else if (diff != '0) begin
            state_d  = StFault;
            mm_d     = diff;
            sticky_d = 1'b1;
            cnt_d    = CNT_W'(sat_inc(64'(cnt_d), 64'(CntMax)));
            all_ok_d = 1'b0;
          end else begin
            all_ok_d = 1'b1;
          end
        end
        StFault: begin
          // Outputs freeze here; only clear_err (or en/rst) gets us out.
          if (mon.clear_err) begin
            state_d  = StSettle;
            settle_d = SettleRld;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      settle_q <= 4'd0;
      all_ok_q <= 1'b0;
      mm_q     <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      all_ok_q <= all_ok_d;
      mm_q     <= mm_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mon.all_ok       = all_ok_q;
  assign mon.mismatch_vec = mm_q;
  assign mon.err_sticky   = sticky_q;
  assign mon.err_count    = cnt_q;
  assign mon.state_o      = state_q;

endmodule

// File: tb/tb_fanout_tree_monitor.sv
// Directed bench for fanout_tree_monitor: expected outputs are queued as stimulus is
// applied and popped when the DUT reaches the corresponding edge.
module tb_fanout_tree_monitor;
  import fanout_mon_pkg::*;

  localparam int unsigned N  = 20;
  localparam int unsigned SE = 2;
  localparam int unsigned CW = 2;

  typedef struct {
    logic [1:0]    st;
    logic          ok;
    logic [N-1:0]  mm;
    logic          sticky;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fanout_tree_monitor_if #(.N_OUT(N), .CNT_W(CW)) mon ();

  fanout_tree_monitor #(
    .N_OUT (N),
    .SETTLE(SE),
    .CNT_W (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mon(mon.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic push(input logic [1:0] st, input logic ok, input logic [N-1:0] mm,
                      input logic sticky, input logic [CW-1:0] cnt);
    exp_t e;
    e.st = st; e.ok = ok; e.mm = mm; e.sticky = sticky; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic cmp_front(input string tag);
    exp_t e;
    e = exp_q.pop_front();
    chk({tag, ".state"},  64'(mon.state_o),      64'(e.st));
    chk({tag, ".all_ok"}, 64'(mon.all_ok),       64'(e.ok));
    chk({tag, ".mm"},     64'(mon.mismatch_vec), 64'(e.mm));
    chk({tag, ".sticky"}, 64'(mon.err_sticky),   64'(e.sticky));
    chk({tag, ".cnt"},    64'(mon.err_count),    64'(e.cnt));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_cmp(input string tag);
    step();
    cmp_front(tag);
  endtask

  task automatic wait_state(input logic [1:0] target, input int budget, input string tag);
    int k = 0;
    while (mon.state_o !== target && k < budget) begin
      step();
      k++;
    end
    chk({tag, ".reach"}, 64'(mon.state_o), 64'(target));
  endtask

  logic [N-1:0]  pats[4]    = '{20'h00001, 20'h80000, 20'h0F0F0, 20'h12345};
  logic [CW-1:0] cnt_seq[4] = '{2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    logic [CW-1:0] prev_cnt;
    mon.en        = 1'b0;
    mon.clear_err = 1'b0;
    mon.tree_in   = 1'b0;
    mon.leaf      = '1;
    repeat (2) @(posedge clk);
    #1;
    push(2'd0, 1'b0, '0, 1'b0, '0);
    cmp_front("reset");

    // Settle then clean check with root low, leaves high.
    @(negedge clk);
    rst    = 1'b0;
    mon.en = 1'b1;
    push(2'd1, 1'b0, '0, 1'b0, '0); step_cmp("settle1");
    push(2'd1, 1'b0, '0, 1'b0, '0); step_cmp("settle2");
    push(2'd2, 1'b0, '0, 1'b0, '0); step_cmp("check");
    push(2'd2, 1'b1, '0, 1'b0, '0); step_cmp("clean");

    // Root toggles in CHECK; leaves follow one cycle later.
    mon.tree_in = 1'b1;
    push(2'd2, 1'b1, '0, 1'b0, '0); step_cmp("tog_pre");
    mon.leaf = '0;
    push(2'd1, 1'b0, '0, 1'b0, '0); step_cmp("tog_settle");
    push(2'd1, 1'b0, '0, 1'b0, '0); step_cmp("tog_settle2");
    push(2'd2, 1'b0, '0, 1'b0, '0); step_cmp("tog_check");
    push(2'd2, 1'b1, '0, 1'b0, '0); step_cmp("tog_clean");

    // Single stuck leaf.
    mon.leaf = 20'h00400;
    push(2'd2, 1'b1, '0, 1'b0, '0);          step_cmp("flt_pre");
    push(2'd3, 1'b0, 20'h00400, 1'b1, 2'd1); step_cmp("flt");
    mon.leaf    = '1;
    mon.tree_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(2'd3, 1'b0, 20'h00400, 1'b1, 2'd1);
      step_cmp("flt_hold");
    end

    // Repeated faults via en toggle; counter saturates at 3.
    prev_cnt = 2'd1;
    for (int i = 0; i < 4; i++) begin
      mon.en   = 1'b0;
      mon.leaf = 20'hFFFFF ^ pats[i];
      step();
      chk("sat_idle.state", 64'(mon.state_o), 64'(StIdle));
      chk("sat_idle.cnt", 64'(mon.err_count), 64'(prev_cnt));
      mon.en = 1'b1;
      push(2'd3, 1'b0, pats[i], 1'b1, cnt_seq[i]);
      wait_state(StFault, 8, "sat");
      cmp_front("sat");
      prev_cnt = cnt_seq[i];
    end

    // clear_err from FAULT restarts settling with everything cleared.
    mon.clear_err = 1'b1;
    push(2'd1, 1'b0, '0, 1'b0, '0); step_cmp("clear");
    mon.clear_err = 1'b0;
    push(2'd3, 1'b0, 20'h12345, 1'b1, 2'd1);
    wait_state(StFault, 8, "refault");
    cmp_front("refault");

    // en=0 together with clear_err.
    mon.en        = 1'b0;
    mon.clear_err = 1'b1;
    push(2'd0, 1'b0, '0, 1'b0, '0); step_cmp("dis_clr");
    mon.clear_err = 1'b0;

    // Asynchronous reset between edges while in CHECK.
    mon.leaf = '1;
    mon.en   = 1'b1;
    wait_state(StCheck, 8, "pre_rst");
    step();
    chk("pre_rst.all_ok", 64'(mon.all_ok), 64'd1);
    #2 rst = 1'b1;
    #1;
    push(2'd0, 1'b0, '0, 1'b0, '0);
    cmp_front("async_rst");
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fanout_tree_monitor.md
Name: fanout_tree_monitor

Overview:
- Sequential consumer placed directly downstream of the buffered inverter fanout tree (one input `in`, N inverted leaf outputs out1..outN).
- Registers every leaf line and the tree input, then waits a settle window after each input edge.
- Checks that every leaf equals ~in and flags which leaves disagree.
- Keeps a sticky error and a saturating fault count, and is used in silicon/FPGA bring-up of optimized fanout netlists.

Parameters:
N_OUT, 20, number of leaf lines monitored (1..64)
SETTLE, 2, cycles to wait after an input edge before comparing (1..15)
CNT_W, 8, width of the fault counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  monitor enable; 0 forces IDLE
clear_err  input  1  single-cycle pulse; clears sticky error, mismatch_vec, err_count
tree_in  input  1  the signal driving the fanout tree root
leaf  input  N_OUT  tree outputs; leaf[i] = out(i+1)
all_ok  output  1  last compare was clean and in CHECK
mismatch_vec  output  N_OUT  leaves wrong at the faulting compare; held in FAULT
err_sticky  output  1  set on any fault, held until clear_err or rst
err_count  output  CNT_W  number of FAULT entries, saturates at all-ones
state_o  output  2  current FSM state (IDLE=0, SETTLE=1, CHECK=2, FAULT=3)

Behaviour:
- Reset (async, rst=1): all registers are 0; state IDLE; all outputs 0.
- Input stage: in_q<=tree_in, in_qq<=in_q, and leaf_q<=leaf on every clock, independent of state.
  - edge = in_q ^ in_qq.
  - exp = ~in_q.
  - diff = leaf_q ^ {N_OUT{exp}}.
- Latency: a leaf value sampled at edge t is compared during cycle t..t+1. The resulting state, all_ok, mismatch_vec and err_count appear after edge t+1, i.e. 2 edges from the pins.
- IDLE: all_ok=0. en=1 -> SETTLE with settle_cnt=SETTLE-1.
- SETTLE: all_ok=0.
  - edge=1 reloads settle_cnt=SETTLE-1.
  - Otherwise, settle_cnt==0 -> CHECK; else settle_cnt decrements.
- CHECK:
  - edge=1 -> SETTLE (reload), no compare; all_ok<=0.
  - Else diff!=0 -> FAULT: mismatch_vec<=diff, err_sticky<=1, err_count<=sat(err_count+1), all_ok<=0.
  - Else all_ok<=1, stay.
- FAULT: outputs held; leaf and tree_in changes are ignored. clear_err=1 -> SETTLE (reload); mismatch_vec<=0, err_sticky<=0, err_count<=0.
- en=0 in any state -> IDLE next edge and all_ok<=0. mismatch_vec, err_sticky and err_count are kept.
- Priority each edge: en=0 > clear_err > edge > compare.
  - clear_err with en=0: clears and goes to IDLE.
  - clear_err outside FAULT: clears counters and sticky; the state transition otherwise follows the normal rules.
- err_count counts FAULT entries only, not cycles spent in FAULT. At 2^CNT_W-1 it holds.
- rst asserted mid-operation: immediate return to reset values, with no partial update.

Decomposition:
- Shared package fanout_mon_pkg holds:
  - the state enum (IDLE, SETTLE, CHECK, FAULT, 2 bits);
  - the constant STATE_W=2;
  - a saturating-increment function.
- One natural sub-module: fanout_mon_sync, the input register stage producing in_q, edge and leaf_q. It is kept separate so it can later be swapped for a 2-flop synchronizer variant.
- The FSM and counters stay in the top.

Test Plan:
- Settle and clean check: rst, then en=1, tree_in=0, leaf=20'hFFFFF. state_o goes 1 then 2 within SETTLE+2=4 edges; all_ok=1 on the next edge; err_count=0.
- Toggle during CHECK: tree_in 0->1 with leaf following to 20'h00000 after 1 cycle. The FSM re-enters SETTLE, returns to CHECK, and all_ok=1 again with no fault recorded.
- Single-leaf fault: in CHECK with tree_in=1, force leaf=20'h00400. FAULT appears 2 edges later with mismatch_vec=20'h00400, err_sticky=1, err_count=1. Later leaf changes leave mismatch_vec unchanged.
- Clear and saturation: with CNT_W=2, produce 5 fault/clear_err cycles without clearing the counter in between (pulse clear_err only with en=0 already re-raised?). Simpler variant: 5 faults, each separated by en toggle 0->1. Expected err_count sequence 1,2,3,3,3; a final clear_err yields err_count=0, err_sticky=0, state SETTLE.
- Disable and reset priority:
  - en=0 and clear_err=1 asserted together in FAULT gives IDLE with counters cleared.
  - Asserting rst asynchronously between edges in CHECK drops all outputs to 0 immediately.
